// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 1024x768@60 raster timing constants and shared types
package vga_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;

  localparam int CNT_W = 11;

  localparam int HOR_TOTAL_TIME  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int HOR_BLANK_START = H_ACTIVE;
  localparam int HOR_SYNC_START  = H_ACTIVE + H_FP;
  localparam int HOR_SYNC_STOP   = HOR_SYNC_START + H_SYNC - 1;

  localparam int VER_TOTAL_TIME  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int VER_BLANK_START = V_ACTIVE;
  localparam int VER_SYNC_START  = V_ACTIVE + V_FP;
  localparam int VER_SYNC_STOP   = VER_SYNC_START + V_SYNC - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Inclusive range test on an unsigned counter value.
  function automatic logic in_range(input cnt_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - pixel stream passed down the draw chain
interface vga_if;
  import vga_pkg::*;

  cnt_t        hcount;
  cnt_t        vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_mod_counter.sv
// rtl/vga_mod_counter.sv - modulo-N counter exposing next value and wrap strobe
module vga_mod_counter #(
  parameter int N = 2,
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  logic [W-1:0] count;

  assign wrap = en && (count == W'(N - 1));

  always_comb begin
    count_next = count;
    if (en) count_next = wrap ? '0 : count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_next;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running raster counters, sync, blanking and line/frame strobes
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_TOTAL       = HOR_TOTAL_TIME,
  parameter int H_BLANK_START = HOR_BLANK_START,
  parameter int H_SYNC_START  = HOR_SYNC_START,
  parameter int H_SYNC_STOP   = HOR_SYNC_STOP,
  parameter int V_TOTAL       = VER_TOTAL_TIME,
  parameter int V_BLANK_START = VER_BLANK_START,
  parameter int V_SYNC_START  = VER_SYNC_START,
  parameter int V_SYNC_STOP   = VER_SYNC_STOP
) (
  input  logic clk,
  input  logic rst,
  vga_if.out   out,
  output logic line_tick,
  output logic frame_tick
);

  cnt_t h_next;
  cnt_t v_next;
  logic h_wrap;
  logic v_wrap;

  vga_mod_counter #(.N(H_TOTAL), .W(CNT_W)) u_hcnt (
    .clk        (clk),
    .rst        (rst),
    .en         (1'b1),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  vga_mod_counter #(.N(V_TOTAL), .W(CNT_W)) u_vcnt (
    .clk        (clk),
    .rst        (rst),
    .en         (h_wrap),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  // Everything is decoded from the next-count values so the registered
  // fields and ticks all describe the pixel on out.hcount/out.vcount.
  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= 12'h000;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      out.hcount <= h_next;
      out.vcount <= v_next;
      out.hblnk  <= in_range(h_next, H_BLANK_START, H_TOTAL - 1);
      out.hsync  <= in_range(h_next, H_SYNC_START, H_SYNC_STOP);
      out.vblnk  <= in_range(v_next, V_BLANK_START, V_TOTAL - 1);
      out.vsync  <= in_range(v_next, V_SYNC_START, V_SYNC_STOP);
      out.rgb    <= 12'h000;
      line_tick  <= h_wrap;
      frame_tick <= v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk;
  logic rst;
  logic lt, ft, lt_s, ft_s;
  int   total;
  int   bad;

  vga_if vif ();
  vga_if vif_s ();

  vga_timing_gen dut (
    .clk        (clk),
    .rst        (rst),
    .out        (vif),
    .line_tick  (lt),
    .frame_tick (ft)
  );

  // Shrunken raster: 28 clks/line, 16 lines/frame, 448 clks/frame.
  vga_timing_gen #(
    .H_TOTAL(28), .H_BLANK_START(16), .H_SYNC_START(18), .H_SYNC_STOP(21),
    .V_TOTAL(16), .V_BLANK_START(10), .V_SYNC_START(11), .V_SYNC_STOP(12)
  ) dut_s (
    .clk        (clk),
    .rst        (rst),
    .out        (vif_s),
    .line_tick  (lt_s),
    .frame_tick (ft_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.hblnk, vif.vblnk, vif.rgb, lt, ft} !== 40'h0) begin
        bad++;
        $display("FAIL reset_zero cyc=%0d got=%h want=0", i,
                 {vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.hblnk, vif.vblnk, vif.rgb, lt, ft});
      end
      total++;
      if ({vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync, vif_s.hblnk, vif_s.vblnk, vif_s.rgb, lt_s, ft_s} !== 40'h0) begin
        bad++;
        $display("FAIL reset_zero_small cyc=%0d got=%h want=0", i,
                 {vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync, vif_s.hblnk, vif_s.vblnk, vif_s.rgb, lt_s, ft_s});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({vif.hcount, vif.vcount, vif.hblnk, lt, ft} !== {11'd1, 11'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_release got h=%0d v=%0d hb=%b lt=%b ft=%b want h=1 v=0 hb=0 lt=0 ft=0",
               vif.hcount, vif.vcount, vif.hblnk, lt, ft);
    end
    total++;
    if ({vif_s.hcount, vif_s.vcount} !== {11'd1, 11'd0}) begin
      bad++;
      $display("FAIL reset_release_small got h=%0d v=%0d want h=1 v=0", vif_s.hcount, vif_s.vcount);
    end
  endtask

  task automatic test_line_wrap;
    int n = 0;
    while (vif.hcount !== 11'd1343 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if ({vif.hcount, vif.vcount, lt} !== {11'd1343, 11'd0, 1'b0}) begin
      bad++;
      $display("FAIL wrap_pre got h=%0d v=%0d lt=%b want h=1343 v=0 lt=0", vif.hcount, vif.vcount, lt);
    end
    @(negedge clk);
    total++;
    if ({vif.hcount, vif.vcount, lt} !== {11'd0, 11'd1, 1'b1}) begin
      bad++;
      $display("FAIL wrap_edge got h=%0d v=%0d lt=%b want h=0 v=1 lt=1", vif.hcount, vif.vcount, lt);
    end
    @(negedge clk);
    total++;
    if ({vif.hcount, vif.vcount, lt} !== {11'd1, 11'd1, 1'b0}) begin
      bad++;
      $display("FAIL wrap_post got h=%0d v=%0d lt=%b want h=1 v=1 lt=0", vif.hcount, vif.vcount, lt);
    end
  endtask

  task automatic test_hdecode;
    int   hb_rise = -1;
    int   hb_fall = -1;
    int   hs_rise = -1;
    int   hs_fall = -1;
    int   hs_cnt  = 0;
    logic pb = vif.hblnk;
    logic ps = vif.hsync;
    for (int i = 0; i < 1344; i++) begin
      @(negedge clk);
      if (vif.hblnk && !pb) hb_rise = int'(vif.hcount);
      if (!vif.hblnk && pb) hb_fall = int'(vif.hcount);
      if (vif.hsync && !ps) hs_rise = int'(vif.hcount);
      if (!vif.hsync && ps) hs_fall = int'(vif.hcount);
      if (vif.hsync === 1'b1) hs_cnt++;
      pb = vif.hblnk;
      ps = vif.hsync;
    end
    total++;
    if (hb_rise != 1024) begin bad++; $display("FAIL hblnk_rise got=%0d want=1024", hb_rise); end
    total++;
    if (hb_fall != 0) begin bad++; $display("FAIL hblnk_fall got=%0d want=0", hb_fall); end
    total++;
    if (hs_rise != 1048) begin bad++; $display("FAIL hsync_rise got=%0d want=1048", hs_rise); end
    total++;
    if (hs_fall != 1184) begin bad++; $display("FAIL hsync_fall got=%0d want=1184", hs_fall); end
    total++;
    if (hs_cnt != 136) begin bad++; $display("FAIL hsync_width got=%0d want=136", hs_cnt); end
  endtask

  task automatic test_frame;
    int   n = 0;
    int   last_ft = -1;
    int   period = -1;
    int   ft_cnt = 0, lt_cnt = 0, vb_cnt = 0, vs_cnt = 0, hs_cnt = 0;
    int   vb_rise_v = -1, vs_rise_v = -1, glitch = 0;
    logic pvb, pvs;
    while (ft_s !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    total++;
    if ({ft_s, vif_s.hcount, vif_s.vcount} !== {1'b1, 11'd0, 11'd0}) begin
      bad++;
      $display("FAIL frame_tick_first got ft=%b h=%0d v=%0d want ft=1 h=0 v=0", ft_s, vif_s.hcount, vif_s.vcount);
    end
    pvb = vif_s.vblnk;
    pvs = vif_s.vsync;
    for (int cyc = 0; cyc < 896; cyc++) begin
      if (ft_s === 1'b1) begin
        if (last_ft >= 0) period = cyc - last_ft;
        last_ft = cyc;
        ft_cnt++;
      end
      if (lt_s === 1'b1)        lt_cnt++;
      if (vif_s.vblnk === 1'b1) vb_cnt++;
      if (vif_s.vsync === 1'b1) vs_cnt++;
      if (vif_s.hsync === 1'b1) hs_cnt++;
      if (vif_s.vblnk && !pvb) vb_rise_v = int'(vif_s.vcount);
      if (vif_s.vsync && !pvs) vs_rise_v = int'(vif_s.vcount);
      if (vif_s.vsync !== pvs && vif_s.hcount !== 11'd0) glitch++;
      pvb = vif_s.vblnk;
      pvs = vif_s.vsync;
      @(negedge clk);
    end
    total++;
    if (ft_cnt != 2) begin bad++; $display("FAIL frame_tick_count got=%0d want=2", ft_cnt); end
    total++;
    if (period != 448) begin bad++; $display("FAIL frame_period got=%0d want=448", period); end
    total++;
    if (lt_cnt != 32) begin bad++; $display("FAIL line_tick_count got=%0d want=32", lt_cnt); end
    total++;
    if (vb_cnt != 336) begin bad++; $display("FAIL vblnk_clks got=%0d want=336", vb_cnt); end
    total++;
    if (vs_cnt != 112) begin bad++; $display("FAIL vsync_clks got=%0d want=112", vs_cnt); end
    total++;
    if (hs_cnt != 128) begin bad++; $display("FAIL hsync_clks_small got=%0d want=128", hs_cnt); end
    total++;
    if (vb_rise_v != 10) begin bad++; $display("FAIL vblnk_rise_line got=%0d want=10", vb_rise_v); end
    total++;
    if (vs_rise_v != 11) begin bad++; $display("FAIL vsync_rise_line got=%0d want=11", vs_rise_v); end
    total++;
    if (glitch != 0) begin bad++; $display("FAIL vsync_off_wrap got=%0d want=0", glitch); end
  endtask

  task automatic test_mid_reset;
    int n = 0;
    while (vif.hcount !== 11'd700 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (vif.hcount !== 11'd700) begin
      bad++;
      $display("FAIL mid_reset_reach got h=%0d want=700", vif.hcount);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.hblnk, vif.vblnk, vif.rgb, lt, ft} !== 40'h0) begin
      bad++;
      $display("FAIL mid_reset_zero got=%h want=0",
               {vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.hblnk, vif.vblnk, vif.rgb, lt, ft});
    end
    total++;
    if ({vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync, vif_s.hblnk, vif_s.vblnk, vif_s.rgb, lt_s, ft_s} !== 40'h0) begin
      bad++;
      $display("FAIL mid_reset_zero_small got=%h want=0",
               {vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync, vif_s.hblnk, vif_s.vblnk, vif_s.rgb, lt_s, ft_s});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.hblnk, vif.vblnk} !== {11'd1, 11'd0, 4'b0000}) begin
      bad++;
      $display("FAIL mid_reset_restart got h=%0d v=%0d hs=%b vs=%b want h=1 v=0 hs=0 vs=0",
               vif.hcount, vif.vcount, vif.hsync, vif.vsync);
    end
  endtask

  // Independent model of both rasters from (1,0), checked every clk.
  task automatic test_protocol;
    int   mh = 1, mv = 0, sh = 1, sv = 0;
    logic [39:0] exp_d, exp_s;
    for (int cyc = 0; cyc < 896; cyc++) begin
      @(negedge clk);
      if (mh == 1343) begin mh = 0; mv = (mv == 805) ? 0 : mv + 1; end
      else mh++;
      if (sh == 27) begin sh = 0; sv = (sv == 15) ? 0 : sv + 1; end
      else sh++;
      exp_d = {11'(mh), 11'(mv), (mh >= 1048 && mh <= 1183), (mv >= 771 && mv <= 776),
               (mh >= 1024), (mv >= 768), 12'h000, (mh == 0), (mh == 0 && mv == 0)};
      exp_s = {11'(sh), 11'(sv), (sh >= 18 && sh <= 21), (sv >= 11 && sv <= 12),
               (sh >= 16), (sv >= 10), 12'h000, (sh == 0), (sh == 0 && sv == 0)};
      total++;
      if ({vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.hblnk, vif.vblnk, vif.rgb, lt, ft} !== exp_d) begin
        bad++;
        $display("FAIL stream cyc=%0d got=%h want=%h", cyc,
                 {vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.hblnk, vif.vblnk, vif.rgb, lt, ft}, exp_d);
      end
      total++;
      if ({vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync, vif_s.hblnk, vif_s.vblnk, vif_s.rgb, lt_s, ft_s} !== exp_s) begin
        bad++;
        $display("FAIL stream_small cyc=%0d got=%h want=%h", cyc,
                 {vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync, vif_s.hblnk, vif_s.vblnk, vif_s.rgb, lt_s, ft_s}, exp_s);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    test_reset();
    test_line_wrap();
    test_hdecode();
    test_frame();
    test_mid_reset();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
